// File: rtl/aes_key_sched_ctrl_pkg.sv
// aes_key_pkg: shared types, constants and small helpers for the AES-128
// key-schedule controller.
//   state_e    : controller FSM states
//   NUM_ROUNDS : number of round keys after key 0 (AES-128 only)
//   RCON_INIT  : Rcon value used for round 1
//   RCON_POLY  : reduction constant of the AES field polynomial
//   xtime()    : multiply by x in GF(2^8)
//   rot_word() : cyclic left rotation of a word by one byte
package aes_key_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_e;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  RCON_POLY  = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// aes_key_sched_ctrl_if: start/key input, round-key valid/ready output and
// the S-box request/result pair of the key-schedule controller.
//   start_i/key_i        : expansion request and 128-bit cipher key
//   rk_o/rk_round_o      : current round key and its index
//   rk_valid_o/rk_ready_i: round-key handshake
//   sub_word_o/sub_word_i: RotWord(w3) to shared S-box, SubWord result back
//   busy_o/done_o        : expansion in progress / completion pulse
// slave is the controller side, master the environment side.
interface aes_key_sched_ctrl_if;

  logic         start_i;
  logic [127:0] key_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_round_o;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic [31:0]  sub_word_o;
  logic [31:0]  sub_word_i;
  logic         busy_o;
  logic         done_o;

  modport slave (
    input  start_i, key_i, rk_ready_i, sub_word_i,
    output rk_o, rk_round_o, rk_valid_o, sub_word_o, busy_o, done_o
  );

  modport master (
    output start_i, key_i, rk_ready_i, sub_word_i,
    input  rk_o, rk_round_o, rk_valid_o, sub_word_o, busy_o, done_o
  );

endinterface

// File: rtl/aes_key_sched_ctrl_key_round_step.sv
// key_round_step: one combinational AES-128 key-expansion step.
//   key_i      : current round key {w0,w1,w2,w3}
//   sub_word_i : SubWord(RotWord(w3)) from the shared S-box
//   rcon_i     : round constant for the key being produced
//   key_o      : next round key {n0,n1,n2,n3}
module key_round_step
  import aes_key_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [31:0]  sub_word_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign t  = sub_word_i ^ {rcon_i, 24'h0};
  // Each new word chains off the one just produced.
  assign n0 = key_i[127:96] ^ t;
  assign n1 = key_i[95:64]  ^ n0;
  assign n2 = key_i[63:32]  ^ n1;
  assign n3 = key_i[31:0]   ^ n2;

  assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES-128 key-expansion controller.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : slave side of aes_key_sched_ctrl_if (start/key in, round keys
//           out on valid/ready, S-box request/result, busy/done status)
// Round keys 0..10 are presented one per accepted handshake. The S-box is
// external and combinational; its result feeds the key register directly.
//
// state  | meaning
// IDLE   | waiting for start_i, no round key offered
// EXPAND | round key rk_round_o offered, advancing on each handshake
module aes_key_sched_ctrl
  import aes_key_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  aes_key_sched_ctrl_if.slave  bus
);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] key_q, key_d;
  logic         done_q, done_d;
  logic [127:0] next_key;

  key_round_step u_step (
    .key_i      (key_q),
    .sub_word_i (bus.sub_word_i),
    .rcon_i     (rcon_q),
    .key_o      (next_key)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      rcon_q  <= RCON_INIT;
      key_q   <= 128'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          key_d   = bus.key_i;
          round_d = 4'd0;
          rcon_d  = RCON_INIT;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (bus.rk_ready_i) begin
          if (round_q == 4'(NUM_ROUNDS)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = next_key;
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rk_o       = key_q;
  assign bus.rk_round_o = round_q;
  assign bus.rk_valid_o = (state_q == EXPAND);
  assign bus.busy_o     = (state_q == EXPAND);
  assign bus.done_o     = done_q;
  assign bus.sub_word_o = rot_word(key_q[31:0]);

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed/randomized bench for aes_key_sched_ctrl.
// Provides a behavioural S-box for the shared S-box port and a word-array
// key-expansion reference model.
module tb_aes_key_sched_ctrl;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  aes_key_sched_ctrl_if bus ();

  aes_key_sched_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, y, s;
    inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    y = inv; s = inv;
    for (int k = 0; k < 4; k++) begin
      y = {y[6:0], y[7]};
      s = s ^ y;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  always_comb bus.sub_word_i = sub_word(bus.sub_word_o);

  task automatic expand_ref(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [7:0]  rc [1:10];
    logic [31:0] tmp;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = sub_word(rotw(tmp)) ^ {rc[i/4], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts an expansion in the current cycle and follows it to done_o.
  // Returns in the done_o cycle so a caller may start again immediately.
  task automatic run_exp(input logic [127:0] key, input bit stall, input bit mid_start);
    int   idx;
    int   cyc;
    logic ready;
    expand_ref(key);
    bus.start_i = 1'b1;
    bus.key_i   = key;
    tick();
    cyc = 1;
    bus.start_i = 1'b0;
    bus.key_i   = rand128();
    idx = 0;
    while (idx <= 10 && cyc < 400) begin
      ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.rk_ready_i = ready;
      bus.start_i    = mid_start && (cyc == 5);
      if (mid_start) bus.key_i = rand128();
      check("valid", {127'h0, bus.rk_valid_o}, 128'h1);
      check("busy", {127'h0, bus.busy_o}, 128'h1);
      check("done_low", {127'h0, bus.done_o}, 128'h0);
      check("round", {124'h0, bus.rk_round_o}, 128'(idx));
      check("rk", bus.rk_o, exp_rk[idx]);
      check("sub_word_o", {96'h0, bus.sub_word_o}, {96'h0, rotw(exp_rk[idx][31:0])});
      if (ready) got_rk[idx] = bus.rk_o;
      tick();
      cyc++;
      if (ready) idx++;
    end
    bus.start_i    = 1'b0;
    bus.rk_ready_i = 1'b0;
    check("all_rounds", 128'(idx), 128'd11);
    check("done_pulse", {127'h0, bus.done_o}, 128'h1);
    check("busy_at_done", {127'h0, bus.busy_o}, 128'h0);
    check("valid_at_done", {127'h0, bus.rk_valid_o}, 128'h0);
    if (!stall) check("done_latency", 128'(cyc), 128'd12);
  endtask

  initial begin
    logic [127:0] fips_key;
    logic [127:0] k;
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.key_i      = 128'h0;
    bus.rk_ready_i = 1'b0;
    tick();
    tick();
    check("rst_rk", bus.rk_o, 128'h0);
    check("rst_round", {124'h0, bus.rk_round_o}, 128'h0);
    check("rst_valid", {127'h0, bus.rk_valid_o}, 128'h0);
    check("rst_busy", {127'h0, bus.busy_o}, 128'h0);
    check("rst_done", {127'h0, bus.done_o}, 128'h0);
    check("rst_sub_word", {96'h0, bus.sub_word_o}, 128'h0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      bus.key_i      = rand128();
      bus.rk_ready_i = 1'b1;
      tick();
      check("idle_valid", {127'h0, bus.rk_valid_o}, 128'h0);
      check("idle_busy", {127'h0, bus.busy_o}, 128'h0);
    end

    // FIPS-197 vector, no backpressure.
    run_exp(fips_key, 1'b0, 1'b0);
    check("fips_r0", got_rk[0], fips_key);
    check("fips_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    check("done_once", {127'h0, bus.done_o}, 128'h0);

    // All-zero key.
    run_exp(128'h0, 1'b0, 1'b0);
    check("zero_r1", got_rk[1], 128'h62636363626363636263636362636363);
    check("zero_r10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    tick();

    // Random backpressure; round 10 only correct if rcon reached 36.
    run_exp(fips_key, 1'b1, 1'b0);
    check("stall_fips_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    for (int n = 0; n < 3; n++) begin
      run_exp(rand128(), 1'b1, 1'b0);
      tick();
    end

    // start_i with a different key mid-expansion is ignored.
    run_exp(fips_key, 1'b0, 1'b1);
    check("mid_start_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();

    // Reset while round 5 is presented.
    k = rand128();
    bus.start_i    = 1'b1;
    bus.key_i      = k;
    tick();
    bus.start_i    = 1'b0;
    bus.rk_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_round", {124'h0, bus.rk_round_o}, 128'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rk_ready_i = 1'b0;
    check("rst5_busy", {127'h0, bus.busy_o}, 128'h0);
    check("rst5_valid", {127'h0, bus.rk_valid_o}, 128'h0);
    check("rst5_done", {127'h0, bus.done_o}, 128'h0);
    check("rst5_rk", bus.rk_o, 128'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst5_no_done", {127'h0, bus.done_o}, 128'h0);
    end
    run_exp(fips_key, 1'b0, 1'b0);
    check("post_rst_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

    // Back-to-back: new start in the done_o cycle of the previous run.
    run_exp(rand128(), 1'b0, 1'b0);
    run_exp(128'h0, 1'b1, 1'b0);
    check("chain_zero_r1", got_rk[1], 128'h62636363626363636263636362636363);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative AES-128 key-expansion controller for the crypto-extension core. Accepts a 128-bit cipher key through a start handshake, then emits round keys 0..10 one per accepted handshake on a valid/ready output port. It owns the round counter and the Rcon register, and sequences the Rcon-XOR/word-chaining step. SubWord is performed by a shared external S-box unit, driven combinationally through a dedicated request/result port pair.

## Interface
- NUM_ROUNDS, 10, number of round keys after key 0; only 10 (AES-128) supported.
- clk_i  input  1  single clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request to begin expansion; sampled only while idle.
- key_i  input  128  cipher key, {w0,w1,w2,w3}, w0 in [127:96]; sampled with start_i.
- rk_o  output  128  current round key {w(4r),w(4r+1),w(4r+2),w(4r+3)}.
- rk_round_o  output  4  round index r of rk_o, 0..10.
- rk_valid_o  output  1  rk_o/rk_round_o valid.
- rk_ready_i  input  1  consumer accepts rk_o this cycle.
- sub_word_o  output  32  RotWord(w3) of current key to shared S-box: {w3[23:0],w3[31:24]}.
- sub_word_i  input  32  SubWord(sub_word_o), combinational same-cycle return.
- busy_o  output  1  expansion in progress (state EXPAND).
- done_o  output  1  one-cycle pulse after round 10 accepted.

## Operation
- FSM states: IDLE, EXPAND.
- IDLE: busy_o=0, rk_valid_o=0. start_i=1 -> load key register from key_i, round=0, rcon=8'h01, go EXPAND.
- EXPAND: rk_valid_o=1, busy_o=1. On rk_valid_o && rk_ready_i:
  - if round<10: key register <= next key, round<=round+1, rcon<=xtime(rcon).
  - if round==10: go IDLE, done_o=1 next cycle.
- No handshake (rk_ready_i=0): rk_o, rk_round_o, rcon held stable; rk_valid_o stays high.
- Next key: t = sub_word_i ^ {rcon,24'h0}; n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2.
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). Rcon sequence per round 1..10: 01,02,04,08,10,20,40,80,1b,36.
- start_i during EXPAND is ignored; key_i ignored outside the start cycle.
- sub_word_o is always driven from the key register (also in IDLE); consumers ignore it unless busy_o=1.
- Reset at any time: state IDLE, round=0, rcon=8'h01, key register=0; in-flight expansion discarded, no done_o.

## Timing
- Reset values: rk_o=0, rk_round_o=0, rk_valid_o=0, busy_o=0, done_o=0, sub_word_o=0.
- start_i accepted in cycle T -> rk_valid_o=1, rk_round_o=0, rk_o=key_i in T+1.
- Round key r+1 presented the cycle after round r is accepted. Minimum 11 cycles from first valid to final acceptance with rk_ready_i held high.
- done_o asserted in the cycle after round-10 acceptance, with busy_o=0. A new start_i is accepted in that same cycle.
- Key register update is the only path through the S-box. sub_word_i -> key register is a single-cycle combinational path, with no pipelining.

## Structure
- Package aes_key_pkg: state enum (IDLE, EXPAND), NUM_ROUNDS constant, RCON_INIT=8'h01, RCON_POLY=8'h1b, xtime function, rot_word function.
- Sub-module key_round_step: combinational; inputs 128-bit key, 32-bit substituted word and 8-bit rcon; output next 128-bit key (Rcon XOR plus w-chain).
- Top holds the FSM, round counter, Rcon register, key register and handshake.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready_i=1 -> round 1 a0fafe1788542cb123a339392a6c7605, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6; done_o pulses once, 12 cycles after start.
- All-zero key -> round 1 62636363626363636263636362636363, round 10 b4ef5bcb3e92e21123e951cf6f8f188e.
- Random rk_ready_i backpressure -> rk_o and rk_round_o stable while unaccepted; the key sequence matches the no-stall run; rcon reaches 36 at round 10.
- start_i pulsed with a different key mid-expansion -> ignored; the original sequence completes unchanged.
- rst_i at round 5 -> next cycle busy_o=0, rk_valid_o=0, no done_o; a fresh start then reproduces round 1 correctly (rcon restarted at 01).
- start_i asserted in the done_o cycle -> accepted; round 0 of the new key is valid in the next cycle.
